// File: rtl/dmem_stage_ctrl.sv
// dmem_stage_ctrl: Y86 data-memory stage between execute and writeback.
// A synchronous word array with byte addressing. Requests use a valid/ready
// handshake and take a configurable number of wait states. Each accepted
// request produces a single-cycle response pulse carrying valM/dmem_error.
//
// Handshake: a request is accepted on a rising clock edge where
// req_valid && req_ready are both high. req_ready is high only in IDLE. While
// req_ready is low, req_valid is ignored. icode/valA/valE/valP are sampled only
// on the accept edge. The response (resp_valid) is a one-cycle pulse and has
// no backpressure.
//
// Optional build macro: DMEM_ALIGN_CHK_EN. When it is defined, a memory access
// whose byte address has non-zero low bits (below the word size) is reported
// as an error and performs no access. When it is undefined, those low bits are
// silently ignored.
module dmem_stage_ctrl #(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valP,
    output logic              resp_valid,
    output logic [DATA_W-1:0] valM,
    output logic              dmem_error,
    output logic              busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } op_t;

    // Storage array; contents are deliberately not reset.
    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    op_t               op_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] valm_q;
    logic              err_q;

    op_t               dec_op;
    logic [DATA_W-1:0] dec_addr;
    logic [DATA_W-1:0] dec_wdata;

    logic              accept;
    logic              commit;
    op_t               c_op;
    logic [DATA_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_idx_full;
    logic [IDX_W-1:0]  c_idx;
    logic              c_oor;
    logic              c_misalign;
    logic              c_err;
    logic              do_write;

    // Decode the incoming instruction into access kind, address and write data.
    always_comb begin
        dec_op    = OP_NONE;
        dec_addr  = valE;
        dec_wdata = valA;
        case (icode)
            4'h4, 4'hA: dec_op = OP_WRITE;
            4'h8: begin
                dec_op    = OP_WRITE;
                dec_wdata = valP;
            end
            4'h5: dec_op = OP_READ;
            4'h9, 4'hB: begin
                dec_op   = OP_READ;
                dec_addr = valA;
            end
            default: dec_op = OP_NONE;
        endcase
    end

    // Next-state logic and handshake outputs of the IDLE/WAIT/RESP controller.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign accept = (state_q == S_IDLE) && req_valid;
    assign commit = (state_d == S_RESP) && (state_q != S_RESP);

    // With zero wait states the commit edge is also the accept edge, so the
    // access must come straight from the decoded inputs rather than the latches.
    always_comb begin
        c_op    = op_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            c_op    = dec_op;
            c_addr  = dec_addr;
            c_wdata = dec_wdata;
        end
    end

    // Range check on the full-width word index so stray upper bits count as errors.
    always_comb begin
        c_idx_full = c_addr >> SHIFT;
        c_idx      = c_idx_full[IDX_W-1:0];
        c_oor      = (c_idx_full >= DEPTH_W);
    end

`ifdef DMEM_ALIGN_CHK_EN
    localparam logic [DATA_W-1:0] LOW_MASK = (DATA_W'(1) << SHIFT) - DATA_W'(1);
    assign c_misalign = ((c_addr & LOW_MASK) != '0);
`else
    assign c_misalign = 1'b0;
`endif

    // Only real memory operations can fault; no-access icodes never do.
    assign c_err    = (c_op != OP_NONE) && (c_oor || c_misalign);
    assign do_write = commit && (c_op == OP_WRITE) && !c_err;

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request on the accept edge; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q    <= dec_op;
            addr_q  <= dec_addr;
            wdata_q <= dec_wdata;
        end
    end

    // Array write port: a write lands only on its commit edge.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[c_idx] <= c_wdata;
        end
    end

    // Response data: updated on the commit edge, held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valm_q <= '0;
            err_q  <= 1'b0;
        end else if (commit) begin
            err_q <= c_err;
            if ((c_op == OP_READ) && !c_err) begin
                valm_q <= mem[c_idx];
            end else begin
                valm_q <= '0;
            end
        end
    end

    assign valM       = valm_q;
    assign dmem_error = err_q;

endmodule
